// File: rtl/riscv_issue_sb_pkg.sv
// rtl/riscv_issue_sb_pkg.sv - class encodings and latency limits shared by the issue scoreboard
package riscv_issue_sb_pkg;

    typedef enum logic [2:0] {
        CLS_EXEC   = 3'd0,
        CLS_LOAD   = 3'd1,
        CLS_STORE  = 3'd2,
        CLS_MUL    = 3'd3,
        CLS_DIV    = 3'd4,
        CLS_CSR    = 3'd5,
        CLS_BRANCH = 3'd6,
        CLS_RSVD   = 3'd7
    } cls_e;

    localparam int CNT_W   = 3;
    localparam int LAT_MAX = 7;

    function automatic int lat_clamp(input int l);
        return (l > LAT_MAX) ? LAT_MAX : ((l < 0) ? 0 : l);
    endfunction

    function automatic logic is_mem(input logic [2:0] c);
        return (c == CLS_LOAD) || (c == CLS_STORE);
    endfunction

endpackage

// File: rtl/riscv_sb_entry.sv
// rtl/riscv_sb_entry.sv - per-register latency countdown and divider-pending flag
module riscv_sb_entry
    import riscv_issue_sb_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             set_div,
    input  logic             clr_div,
    input  logic             hold,
    input  logic             flush,
    output logic             blocked,
    output logic             busy,
    output logic             div_pend
);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             div_pend_q, div_pend_d;

    always_comb begin
        cnt_d      = cnt_q;
        div_pend_d = div_pend_q;
        if (flush) begin
            cnt_d      = '0;
            div_pend_d = 1'b0;
        end else begin
            if (load)
                cnt_d = load_val;
            else if ((cnt_q != '0) && !hold)
                cnt_d = cnt_q - 1'b1;
            // A new DIV can only issue with no divide pending, so set wins over writeback
            if (set_div)
                div_pend_d = 1'b1;
            else if (clr_div)
                div_pend_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q      <= '0;
            div_pend_q <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            div_pend_q <= div_pend_d;
        end
    end

    // Writeback releases its register in the same cycle it arrives
    assign blocked  = (cnt_q != '0) | (div_pend_q & ~clr_div);
    assign busy     = (cnt_q != '0) | div_pend_q;
    assign div_pend = div_pend_q;

endmodule

// File: rtl/riscv_issue_sb.sv
// rtl/riscv_issue_sb.sv - dual-lane issue scoreboard; RISCV_ISSUE_SB_DUAL_EN enables slot-1 issue
module riscv_issue_sb
    import riscv_issue_sb_pkg::*;
#(
    parameter int LOAD_LATENCY = 1,
    parameter int MUL_LATENCY  = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        s0_valid,
    input  logic [4:0]  s0_ra,
    input  logic [4:0]  s0_rb,
    input  logic [4:0]  s0_rd,
    input  logic        s0_rd_valid,
    input  logic [2:0]  s0_class,
    input  logic        s1_valid,
    input  logic [4:0]  s1_ra,
    input  logic [4:0]  s1_rb,
    input  logic [4:0]  s1_rd,
    input  logic        s1_rd_valid,
    input  logic [2:0]  s1_class,
    input  logic        hold,
    input  logic        flush,
    input  logic        div_wb_valid,
    input  logic [4:0]  div_wb_rd,
    output logic        s0_issue,
    output logic        s1_issue,
    output logic [31:0] busy
);

    localparam logic [CNT_W-1:0] LD_LAT  = CNT_W'(lat_clamp(LOAD_LATENCY));
    localparam logic [CNT_W-1:0] MUL_LAT = CNT_W'(lat_clamp(MUL_LATENCY));

    function automatic logic [CNT_W-1:0] lat_of(input logic [2:0] c);
        case (c)
            CLS_LOAD: return LD_LAT;
            CLS_MUL:  return MUL_LAT;
            default:  return '0;
        endcase
    endfunction

    logic        ready_q, ready_d;
    logic [31:0] blocked;
    logic [31:0] div_pend;
    logic        div_any;
    logic        s0_clean;

    logic             s0_wr, s0_div, s1_wr, s1_div;
    logic [CNT_W-1:0] s0_lat, s1_lat;
    logic [4:0]       s1_rd_w;

    always_comb begin
        ready_d = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            ready_q <= 1'b0;
        else
            ready_q <= ready_d;
    end

    assign div_any  = |div_pend;
    assign s0_clean = ~blocked[s0_ra] & ~blocked[s0_rb] & ~(s0_rd_valid & blocked[s0_rd]);
    assign s0_issue = ready_q & ~hold & ~flush & s0_valid & s0_clean
                    & ~((s0_class == CLS_DIV) & div_any);

    assign s0_wr  = s0_issue & s0_rd_valid;
    assign s0_div = (s0_class == CLS_DIV);
    assign s0_lat = lat_of(s0_class);

`ifdef RISCV_ISSUE_SB_DUAL_EN
    logic s1_clean, pair_csr, pair_shared, pair_dep;

    assign s1_clean    = ~blocked[s1_ra] & ~blocked[s1_rb] & ~(s1_rd_valid & blocked[s1_rd]);
    assign pair_csr    = (s0_class == CLS_CSR) | (s1_class == CLS_CSR);
    assign pair_shared = (is_mem(s0_class) & is_mem(s1_class))
                       | ((s0_class == CLS_MUL) & (s1_class == CLS_MUL))
                       | ((s0_class == CLS_DIV) & (s1_class == CLS_DIV))
                       | ((s0_class == CLS_BRANCH) & (s1_class == CLS_BRANCH));
    // s1 rd is compared even when s1 does not write, keeping the two write ports disjoint
    assign pair_dep    = s0_rd_valid & (s0_rd != 5'd0)
                       & ((s0_rd == s1_ra) | (s0_rd == s1_rb) | (s0_rd == s1_rd));
    assign s1_issue    = s0_issue & s1_valid & s1_clean & ~pair_csr & ~pair_shared & ~pair_dep
                       & ~((s1_class == CLS_DIV) & div_any);

    assign s1_wr   = s1_issue & s1_rd_valid;
    assign s1_div  = (s1_class == CLS_DIV);
    assign s1_lat  = lat_of(s1_class);
    assign s1_rd_w = s1_rd;
`else
    logic unused_s1;

    assign unused_s1 = ^{s1_valid, s1_ra, s1_rb, s1_rd, s1_rd_valid, s1_class};
    assign s1_issue  = 1'b0;
    assign s1_wr     = 1'b0;
    assign s1_div    = 1'b0;
    assign s1_lat    = '0;
    assign s1_rd_w   = '0;
`endif

    assign blocked[0]  = 1'b0;
    assign busy[0]     = 1'b0;
    assign div_pend[0] = 1'b0;

    for (genvar r = 1; r < 32; r++) begin : g_ent
        logic s0_hit, s1_hit;

        assign s0_hit = s0_wr & (s0_rd == 5'(r));
        assign s1_hit = s1_wr & (s1_rd_w == 5'(r));

        riscv_sb_entry u_ent (
            .clk      (clk),
            .rst_n    (rst_n),
            .load     ((s0_hit & ~s0_div) | (s1_hit & ~s1_div)),
            .load_val (s0_hit ? s0_lat : s1_lat),
            .set_div  ((s0_hit & s0_div) | (s1_hit & s1_div)),
            .clr_div  (div_wb_valid & (div_wb_rd == 5'(r))),
            .hold     (hold),
            .flush    (flush),
            .blocked  (blocked[r]),
            .busy     (busy[r]),
            .div_pend (div_pend[r])
        );
    end

endmodule

// File: tb/tb_riscv_issue_sb.sv
// tb/tb_riscv_issue_sb.sv - directed and randomized bench for riscv_issue_sb against a register-level model
module tb_riscv_issue_sb;

    localparam int EXEC = 0, LOAD = 1, STORE = 2, MUL = 3, DIV = 4, CSR = 5, BRANCH = 6;
    localparam int LD_LAT  = 1;
    localparam int MUL_LAT = 1;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        s0_valid, s1_valid, s0_rd_valid, s1_rd_valid;
    logic [4:0]  s0_ra, s0_rb, s0_rd, s1_ra, s1_rb, s1_rd;
    logic [2:0]  s0_class, s1_class;
    logic        hold, flush, div_wb_valid;
    logic [4:0]  div_wb_rd;
    logic        s0_issue, s1_issue;
    logic [31:0] busy;

    always #5 clk = ~clk;

    riscv_issue_sb dut (
        .clk(clk), .rst_n(rst_n),
        .s0_valid(s0_valid), .s0_ra(s0_ra), .s0_rb(s0_rb), .s0_rd(s0_rd),
        .s0_rd_valid(s0_rd_valid), .s0_class(s0_class),
        .s1_valid(s1_valid), .s1_ra(s1_ra), .s1_rb(s1_rb), .s1_rd(s1_rd),
        .s1_rd_valid(s1_rd_valid), .s1_class(s1_class),
        .hold(hold), .flush(flush), .div_wb_valid(div_wb_valid), .div_wb_rd(div_wb_rd),
        .s0_issue(s0_issue), .s1_issue(s1_issue), .busy(busy)
    );

    int  mcnt [32];
    bit  mdiv [32];
    bit  mready;
    int  n_cmp = 0;
    int  n_err = 0;
    logic        obs_s0, obs_s1;
    logic [31:0] obs_busy;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int cls_n(input logic [2:0] c);
        return (int'(c) == 7) ? EXEC : int'(c);
    endfunction

    function automatic bit blk(input int r);
        if (r == 0) return 1'b0;
        return (mcnt[r] > 0) || (mdiv[r] && !(div_wb_valid && int'(div_wb_rd) == r));
    endfunction

    function automatic bit clean(input int ra, input int rb, input int rd, input bit rdv);
        return !blk(ra) && !blk(rb) && !(rdv && blk(rd));
    endfunction

    function automatic bit any_div();
        bit a = 1'b0;
        for (int r = 0; r < 32; r++) a |= mdiv[r];
        return a;
    endfunction

    function automatic int lat(input int c);
        return (c == LOAD) ? LD_LAT : ((c == MUL) ? MUL_LAT : 0);
    endfunction

    task automatic model_reset();
        for (int r = 0; r < 32; r++) begin
            mcnt[r] = 0;
            mdiv[r] = 1'b0;
        end
        mready = 1'b0;
    endtask

    task automatic model_issue(output bit e0, output bit e1);
        int c0 = cls_n(s0_class);
        int c1 = cls_n(s1_class);
        bit mem0 = (c0 == LOAD) || (c0 == STORE);
        bit mem1 = (c1 == LOAD) || (c1 == STORE);
        bit shared, dep;
        e0 = mready && rst_n && !hold && !flush && s0_valid
             && clean(s0_ra, s0_rb, s0_rd, s0_rd_valid) && !(c0 == DIV && any_div());
        shared = (mem0 && mem1) || (c0 == MUL && c1 == MUL) || (c0 == DIV && c1 == DIV)
                 || (c0 == BRANCH && c1 == BRANCH);
        dep = s0_rd_valid && s0_rd != 0 && (s0_rd == s1_ra || s0_rd == s1_rb || s0_rd == s1_rd);
`ifdef RISCV_ISSUE_SB_DUAL_EN
        e1 = e0 && s1_valid && clean(s1_ra, s1_rb, s1_rd, s1_rd_valid) && c0 != CSR && c1 != CSR
             && !shared && !dep && !(c1 == DIV && any_div());
`else
        e1 = 1'b0 & shared & dep;
`endif
    endtask

    task automatic model_write(input bit iss, input int rd, input bit rdv, input int c, inout int nc [32]);
        if (iss && rdv && rd != 0) begin
            if (c == DIV) mdiv[rd] = 1'b1;
            else          nc[rd] = lat(c);
        end
    endtask

    task automatic model_update(input bit e0, input bit e1);
        int nc [32];
        mready = 1'b1;
        if (flush) begin
            for (int r = 0; r < 32; r++) begin
                mcnt[r] = 0;
                mdiv[r] = 1'b0;
            end
            return;
        end
        for (int r = 0; r < 32; r++)
            nc[r] = (mcnt[r] > 0 && !hold) ? mcnt[r] - 1 : mcnt[r];
        if (div_wb_valid) mdiv[div_wb_rd] = 1'b0;
        model_write(e0, s0_rd, s0_rd_valid, cls_n(s0_class), nc);
        model_write(e1, s1_rd, s1_rd_valid, cls_n(s1_class), nc);
        for (int r = 0; r < 32; r++) mcnt[r] = nc[r];
    endtask

    task automatic cycle();
        bit e0, e1;
        logic [31:0] eb;
        @(negedge clk);
        if (!rst_n) model_reset();
        model_issue(e0, e1);
        for (int r = 0; r < 32; r++) eb[r] = (mcnt[r] > 0) || mdiv[r];
        obs_s0   = s0_issue;
        obs_s1   = s1_issue;
        obs_busy = busy;
        check("s0_issue", s0_issue, e0);
        check("s1_issue", s1_issue, e1);
        check("busy", busy, eb);
        @(posedge clk);
        if (rst_n) model_update(e0, e1);
        #1;
    endtask

    task automatic set0(input bit v, input int c, input int ra, input int rb, input int rd, input bit rdv);
        s0_valid = v; s0_class = 3'(c); s0_ra = 5'(ra); s0_rb = 5'(rb); s0_rd = 5'(rd); s0_rd_valid = rdv;
    endtask

    task automatic set1(input bit v, input int c, input int ra, input int rb, input int rd, input bit rdv);
        s1_valid = v; s1_class = 3'(c); s1_ra = 5'(ra); s1_rb = 5'(rb); s1_rd = 5'(rd); s1_rd_valid = rdv;
    endtask

    task automatic idle();
        set0(0, EXEC, 0, 0, 0, 0);
        set1(0, EXEC, 0, 0, 0, 0);
        hold = 0; flush = 0; div_wb_valid = 0; div_wb_rd = 0;
    endtask

    initial begin
        rst_n = 1'b0;
        idle();
        model_reset();
        cycle();
        cycle();
        check("reset_busy", obs_busy, 32'h0);

        // First issue two cycles after reset release
        rst_n = 1'b1;
        set0(1, EXEC, 3, 4, 1, 1);
        cycle();
        check("rel_first", obs_s0, 0);
        cycle();
        check("rel_second", obs_s0, 1);

        // Load-use bubble
        set0(1, LOAD, 1, 2, 5, 1);
        cycle();
        set0(1, EXEC, 5, 1, 6, 1);
        cycle();
        check("ld_use_c1", obs_s0, 0);
        cycle();
        check("ld_use_c2", obs_s0, 1);
        idle();
        cycle();

        // Independent pair, then dependent pair
        set0(1, EXEC, 3, 4, 1, 1);
        set1(1, EXEC, 3, 4, 2, 1);
        cycle();
`ifdef RISCV_ISSUE_SB_DUAL_EN
        check("pair_indep_s1", obs_s1, 1);
`endif
        set1(1, EXEC, 1, 4, 2, 1);
        cycle();
        check("pair_dep_s1", obs_s1, 0);
        set0(1, EXEC, 1, 4, 2, 1);
        set1(0, EXEC, 0, 0, 0, 0);
        cycle();
        check("pair_dep_next", obs_s0, 1);

        // Divider pending, consumer released by writeback
        set0(1, DIV, 1, 2, 7, 1);
        cycle();
        set0(1, EXEC, 7, 0, 8, 1);
        for (int i = 0; i < 3; i++) cycle();
        check("div_wait", obs_s0, 0);
        set0(1, DIV, 3, 4, 10, 1);
        cycle();
        check("div_second_blk", obs_s0, 0);
        set0(1, EXEC, 7, 0, 8, 1);
        div_wb_valid = 1; div_wb_rd = 7;
        cycle();
        check("div_wb_release", obs_s0, 1);
        idle();
        set0(1, DIV, 3, 4, 10, 1);
        cycle();
        check("div_second_go", obs_s0, 1);
        idle();
        div_wb_valid = 1; div_wb_rd = 10;
        cycle();
        idle();

        // Hold freezes a MUL countdown
        set0(1, MUL, 1, 2, 9, 1);
        cycle();
        idle();
        hold = 1;
        for (int i = 0; i < 3; i++) begin
            cycle();
            check("hold_busy9", obs_busy[9], 1);
        end
        hold = 0;
        cycle();
        check("post_hold_busy9", obs_busy[9], 1);
        cycle();
        check("post_hold_clr9", obs_busy[9], 0);

        // Flush with a pending divide and a pending load
        set0(1, DIV, 1, 2, 7, 1);
        cycle();
        set0(1, LOAD, 1, 2, 5, 1);
        cycle();
        set0(1, EXEC, 1, 2, 3, 1);
        flush = 1;
        cycle();
        check("flush_issue", obs_s0, 0);
        check("flush_busy_pre", obs_busy[7] & obs_busy[5], 1);
        idle();
        cycle();
        check("flush_busy", obs_busy, 32'h0);

        // Reset mid-operation
        set0(1, LOAD, 1, 2, 5, 1);
        cycle();
        rst_n = 1'b0;
        set0(1, EXEC, 3, 4, 1, 1);
        cycle();
        check("rst_mid_busy", obs_busy, 32'h0);
        check("rst_mid_issue", obs_s0, 0);
        rst_n = 1'b1;
        cycle();
        check("rst_rel_first", obs_s0, 0);
        cycle();
        check("rst_rel_second", obs_s0, 1);

        // Randomized traffic on a small register window to provoke hazards
        for (int n = 0; n < 4000; n++) begin
            rst_n = ($urandom_range(0, 299) != 0);
            set0($urandom_range(0, 9) < 8, $urandom_range(0, 7), $urandom_range(0, 7),
                 $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 4) != 0);
            set1($urandom_range(0, 9) < 8, $urandom_range(0, 7), $urandom_range(0, 7),
                 $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 4) != 0);
            hold         = ($urandom_range(0, 7) == 0);
            flush        = ($urandom_range(0, 24) == 0);
            div_wb_valid = ($urandom_range(0, 3) == 0);
            div_wb_rd    = 5'($urandom_range(0, 7));
            cycle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
